// File: rtl/ts_chan_filter_pkg.sv
// Shared constants, parser state encoding and channel table entry type
// for the TS channel filter.
package ts_chan_pkg;

  localparam int TS_WORDS = 47;
  localparam int TS_BYTES = 188;
  localparam logic [7:0] TS_SYNC = 8'h47;

  // Parser states
  localparam logic [1:0] P_IDLE = 2'd0;
  localparam logic [1:0] P_IP   = 2'd1;
  localparam logic [1:0] P_PORT = 2'd2;
  localparam logic [1:0] P_TS   = 2'd3;

  // One channel table entry; bit layout matches cfg_data
  typedef struct packed {
    logic        valid;
    logic [7:0]  sfp;
    logic [31:0] ip;
    logic [15:0] port;
  } chan_entry_t;

  // Saturating 16-bit increment for the statistics counters
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ts_chan_filter_if.sv
// Stream interface of the TS channel filter: splitter words in, tagged
// TS bytes out.
//
// Handshake: the input side has no backpressure; every cycle with
// ts_din_en=1 carries one word that must be consumed. On the output side
// a byte transfers on a rising clock edge where ts_dout_en & ts_dout_rdy;
// while ts_dout_en=1 and ts_dout_rdy=0 the byte, sof and chan hold.
interface ts_chan_filter_if #(
  parameter int CHAN_W = 3
);
  logic [32:0]       ts_din;
  logic              ts_din_en;
  logic [7:0]        ts_dout;
  logic              ts_dout_en;
  logic              ts_dout_sof;
  logic [CHAN_W-1:0] ts_dout_chan;
  logic              ts_dout_rdy;

  modport master (
    output ts_din, ts_din_en, ts_dout_rdy,
    input  ts_dout, ts_dout_en, ts_dout_sof, ts_dout_chan
  );

  modport slave (
    input  ts_din, ts_din_en, ts_dout_rdy,
    output ts_dout, ts_dout_en, ts_dout_sof, ts_dout_chan
  );
endinterface

// File: rtl/ts_chan_filter_pkt_buf.sv
// Two-bank TS packet buffer: simple dual-port RAM with a registered read.
// Address is {bank, word[5:0]}; each bank holds one 47-word packet.
import ts_chan_pkg::*;

module ts_pkt_buf (
  input  logic        clk,
  input  logic        wr_en,
  input  logic [6:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic        rd_en,
  input  logic [6:0]  rd_addr,
  output logic [31:0] rd_data
);

  logic [31:0] mem [0:1][0:TS_WORDS-1];

  // Write port and registered read port
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr[6]][wr_addr[5:0]] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr[6]][rd_addr[5:0]];
  end

endmodule

// File: rtl/ts_chan_filter.sv
// TS channel filter: parses splitter groups, matches {sfp, ip, port}
// against a programmable table, buffers matched packets in two banks and
// replays them as a channel-tagged byte stream.
import ts_chan_pkg::*;

module ts_chan_filter #(
  parameter int CHAN_NUM = 8,
  parameter int CHAN_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  ts_chan_filter_if.slave   bus,
  input  logic              cfg_wr,
  input  logic [CHAN_W-1:0] cfg_addr,
  input  logic [56:0]       cfg_data,
  output logic [15:0]       drop_cnt,
  output logic [15:0]       err_cnt,
  output logic [1:0]        dbg_state
);

  localparam logic [5:0] LAST_WORD = 6'(TS_WORDS - 1);

  chan_entry_t       tbl [CHAN_NUM];
  logic [1:0]        p_state;
  logic [7:0]        sfp_r;
  logic [31:0]       ip_r;
  logic              hit_r, bank_ok_r, bad_r;
  logic [CHAN_W-1:0] chan_r;
  logic [5:0]        wcnt;
  logic              wr_bank;
  logic [1:0]        full;
  logic [CHAN_W-1:0] bank_chan [2];

  logic              lk_hit;
  logic [CHAN_W-1:0] lk_chan;
  logic              is_h, ts_word, last_word, commit, err_inc, drop_inc;

  logic              rd_active, rd_bank;
  logic [1:0]        bidx;
  logic [5:0]        widx;
  logic [CHAN_W-1:0] out_chan;
  logic              xfer, word_done, rd_last, rd_start, rd_chain, rd_next;
  logic              ram_rd_en, ram_wr_en;
  logic [6:0]        ram_rd_addr;
  logic [31:0]       rd_data;
  logic [7:0]        byte_sel;

  // Channel table, written through the cfg port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CHAN_NUM; i++) tbl[i] <= '0;
    end else if (cfg_wr) begin
      tbl[cfg_addr] <= chan_entry_t'(cfg_data);
    end
  end

  // Parallel lookup; scanning downwards leaves the lowest matching index
  always_comb begin
    lk_hit  = 1'b0;
    lk_chan = '0;
    for (int i = CHAN_NUM - 1; i >= 0; i--) begin
      if (tbl[i].valid && tbl[i].sfp == sfp_r && tbl[i].ip == ip_r &&
          tbl[i].port == bus.ts_din[15:0]) begin
        lk_hit  = 1'b1;
        lk_chan = CHAN_W'(i);
      end
    end
  end

  // Input word classification and event strobes
  always_comb begin
    is_h      = bus.ts_din_en & bus.ts_din[32];
    ts_word   = bus.ts_din_en & ~bus.ts_din[32] & (p_state == P_TS);
    last_word = ts_word & (wcnt == LAST_WORD);
    commit    = last_word & hit_r & bank_ok_r & ~bad_r;
    err_inc   = (is_h & (p_state == P_TS) & hit_r) | (last_word & hit_r & bad_r);
    drop_inc  = bus.ts_din_en & ~bus.ts_din[32] & (p_state == P_PORT) &
                lk_hit & full[wr_bank];
    ram_wr_en = ts_word & hit_r & bank_ok_r;
  end

  // Parser FSM; a marker word in any state restarts the group
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_state   <= P_IDLE;
      sfp_r     <= '0;
      ip_r      <= '0;
      hit_r     <= 1'b0;
      bank_ok_r <= 1'b0;
      bad_r     <= 1'b0;
      chan_r    <= '0;
      wcnt      <= '0;
      wr_bank   <= 1'b0;
      bank_chan[0] <= '0;
      bank_chan[1] <= '0;
    end else if (bus.ts_din_en) begin
      if (bus.ts_din[32]) begin
        sfp_r   <= bus.ts_din[7:0];
        p_state <= P_IP;
      end else begin
        case (p_state)
          P_IP: begin
            ip_r    <= bus.ts_din[31:0];
            p_state <= P_PORT;
          end
          P_PORT: begin
            hit_r     <= lk_hit;
            chan_r    <= lk_chan;
            bank_ok_r <= ~full[wr_bank];
            bad_r     <= 1'b0;
            wcnt      <= '0;
            p_state   <= P_TS;
          end
          P_TS: begin
            wcnt <= 6'(wcnt + 6'd1);
            if (wcnt == 6'd0) bad_r <= (bus.ts_din[31:24] != TS_SYNC);
            if (wcnt == LAST_WORD) begin
              p_state <= P_IDLE;
              if (commit) begin
                bank_chan[wr_bank] <= chan_r;
                wr_bank            <= ~wr_bank;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Saturating drop and error counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      if (drop_inc) drop_cnt <= sat_inc(drop_cnt);
      if (err_inc)  err_cnt  <= sat_inc(err_cnt);
    end
  end

  // Bank full flags: set on commit, cleared after the last byte leaves
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full <= 2'b00;
    end else begin
      if (commit)  full[wr_bank] <= 1'b1;
      if (rd_last) full[rd_bank] <= 1'b0;
    end
  end

  // Reader control: the RAM output register holds the word being emitted,
  // and the next word is fetched as the last byte of the current one moves
  always_comb begin
    xfer      = rd_active & bus.ts_dout_rdy;
    word_done = xfer & (bidx == 2'd3);
    rd_last   = word_done & (widx == LAST_WORD);
    rd_next   = word_done & (widx != LAST_WORD);
    rd_chain  = rd_last & full[~rd_bank];
    rd_start  = ~rd_active & full[rd_bank];
    ram_rd_en = rd_start | rd_next | rd_chain;
    if (rd_chain)     ram_rd_addr = {~rd_bank, 6'd0};
    else if (rd_next) ram_rd_addr = {rd_bank, 6'(widx + 6'd1)};
    else              ram_rd_addr = {rd_bank, 6'd0};
  end

  // Reader position, bank pointer and latched channel
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_active <= 1'b0;
      rd_bank   <= 1'b0;
      bidx      <= '0;
      widx      <= '0;
      out_chan  <= '0;
    end else if (rd_start) begin
      rd_active <= 1'b1;
      bidx      <= '0;
      widx      <= '0;
      out_chan  <= bank_chan[rd_bank];
    end else if (xfer) begin
      bidx <= 2'(bidx + 2'd1);
      if (bidx == 2'd3) begin
        if (widx == LAST_WORD) begin
          rd_bank <= ~rd_bank;
          if (full[~rd_bank]) begin
            widx     <= '0;
            out_chan <= bank_chan[~rd_bank];
          end else begin
            rd_active <= 1'b0;
          end
        end else begin
          widx <= 6'(widx + 6'd1);
        end
      end
    end
  end

  // MSB-first byte select from the current word
  always_comb begin
    case (bidx)
      2'd0:    byte_sel = rd_data[31:24];
      2'd1:    byte_sel = rd_data[23:16];
      2'd2:    byte_sel = rd_data[15:8];
      default: byte_sel = rd_data[7:0];
    endcase
  end

  assign bus.ts_dout      = rd_active ? byte_sel : 8'h00;
  assign bus.ts_dout_en   = rd_active;
  assign bus.ts_dout_sof  = rd_active & (widx == 6'd0) & (bidx == 2'd0);
  assign bus.ts_dout_chan = out_chan;
  assign dbg_state        = p_state;

  ts_pkt_buf u_buf (
    .clk     (clk),
    .wr_en   (ram_wr_en),
    .wr_addr ({wr_bank, wcnt}),
    .wr_data (bus.ts_din[31:0]),
    .rd_en   (ram_rd_en),
    .rd_addr (ram_rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_ts_chan_filter.sv
// Directed bench for ts_chan_filter: one task per scenario, byte-level
// scoreboard of {sof, chan, byte} entries.
module tb_ts_chan_filter;
  import ts_chan_pkg::*;

  localparam int CHAN_W = 3;
  localparam int W = 12;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cfg_wr = 1'b0;
  logic [CHAN_W-1:0] cfg_addr = '0;
  logic [56:0]       cfg_data = '0;
  logic [15:0]       drop_cnt, err_cnt;
  logic [1:0]        dbg_state;
  logic              rnd_done = 1'b0;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];

  localparam logic [7:0]  A_SFP = 8'h01;
  localparam logic [31:0] A_IP  = 32'hC0A80001;
  localparam logic [15:0] A_PORT = 16'h1234;
  localparam logic [7:0]  B_SFP = 8'h02;
  localparam logic [31:0] B_IP  = 32'h0A000001;
  localparam logic [15:0] B_PORT = 16'h5000;

  ts_chan_filter_if #(.CHAN_W(CHAN_W)) bus ();

  ts_chan_filter #(.CHAN_NUM(8), .CHAN_W(CHAN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .cfg_wr    (cfg_wr),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .drop_cnt  (drop_cnt),
    .err_cnt   (err_cnt),
    .dbg_state (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Output monitor: record every transferred byte
  always @(negedge clk) begin
    if (rst && bus.ts_dout_en && bus.ts_dout_rdy)
      got_q.push_back({bus.ts_dout_sof, bus.ts_dout_chan, bus.ts_dout});
  end

  function automatic logic [7:0] pkt_byte(input int seed, input int idx, input logic [7:0] sync);
    if (idx == 0) return sync;
    return 8'((seed * 37 + idx * 11 + (idx >> 2)) & 255);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [32:0] w);
    bus.ts_din    = w;
    bus.ts_din_en = 1'b1;
    tick();
    bus.ts_din_en = 1'b0;
  endtask

  task automatic cfg_write(input logic [CHAN_W-1:0] a, input logic [56:0] d);
    cfg_wr   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    tick();
    cfg_wr   = 1'b0;
  endtask

  task automatic send_group(input logic [7:0] sfp, input logic [31:0] ip, input logic [15:0] port,
                            input int seed, input int nwords, input logic [7:0] sync);
    drive({1'b1, 24'h0, sfp});
    drive({1'b0, ip});
    drive({1'b0, 16'h0, port});
    for (int w = 0; w < nwords; w++)
      drive({1'b0, pkt_byte(seed, 4*w, sync), pkt_byte(seed, 4*w+1, sync),
             pkt_byte(seed, 4*w+2, sync), pkt_byte(seed, 4*w+3, sync)});
  endtask

  task automatic expect_pkt(input logic [CHAN_W-1:0] chan, input int seed);
    for (int i = 0; i < TS_BYTES; i++)
      exp_q.push_back({(i == 0), chan, pkt_byte(seed, i, TS_SYNC)});
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.ts_din = '0;
    bus.ts_din_en = 1'b0;
    bus.ts_dout_rdy = 1'b1;
    repeat (3) tick();
    checks++; if (bus.ts_dout_en !== 1'b0) begin failures++; $display("FAIL reset_en got=%0b exp=0", bus.ts_dout_en); end
    checks++; if (bus.ts_dout !== 8'h00) begin failures++; $display("FAIL reset_dout got=%02h exp=00", bus.ts_dout); end
    checks++; if (bus.ts_dout_sof !== 1'b0) begin failures++; $display("FAIL reset_sof got=%0b exp=0", bus.ts_dout_sof); end
    checks++; if (bus.ts_dout_chan !== 3'd0) begin failures++; $display("FAIL reset_chan got=%0d exp=0", bus.ts_dout_chan); end
    checks++; if (drop_cnt !== 16'd0) begin failures++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt); end
    checks++; if (err_cnt !== 16'd0) begin failures++; $display("FAIL reset_err got=%0d exp=0", err_cnt); end
    checks++; if (dbg_state !== P_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, P_IDLE); end
    rst = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_match();
    got_q.delete(); exp_q.delete();
    expect_pkt(3'd2, 1);
    send_group(A_SFP, A_IP, A_PORT, 1, TS_WORDS, TS_SYNC);
    @(negedge clk);
    checks++; if (bus.ts_dout_en !== 1'b0) begin failures++; $display("FAIL match_early_en got=%0b exp=0", bus.ts_dout_en); end
    @(negedge clk);
    checks++; if (bus.ts_dout_en !== 1'b1) begin failures++; $display("FAIL match_lat_en got=%0b exp=1", bus.ts_dout_en); end
    checks++; if (bus.ts_dout_sof !== 1'b1) begin failures++; $display("FAIL match_lat_sof got=%0b exp=1", bus.ts_dout_sof); end
    checks++; if (bus.ts_dout !== 8'h47) begin failures++; $display("FAIL match_lat_dout got=%02h exp=47", bus.ts_dout); end
    checks++; if (bus.ts_dout_chan !== 3'd2) begin failures++; $display("FAIL match_lat_chan got=%0d exp=2", bus.ts_dout_chan); end
    tick();
    repeat (250) tick();
    checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL match_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL match_byte[%0d] got=%03h exp=%03h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (drop_cnt !== 16'd0) begin failures++; $display("FAIL match_drop got=%0d exp=0", drop_cnt); end
    checks++; if (err_cnt !== 16'd0) begin failures++; $display("FAIL match_err got=%0d exp=0", err_cnt); end
  endtask

  task automatic test_port_miss();
    got_q.delete(); exp_q.delete();
    send_group(A_SFP, A_IP, 16'h1235, 2, TS_WORDS, TS_SYNC);
    repeat (250) tick();
    checks++; if (got_q.size() !== 0) begin failures++; $display("FAIL miss_count got=%0d exp=0", got_q.size()); end
    checks++; if (drop_cnt !== 16'd0) begin failures++; $display("FAIL miss_drop got=%0d exp=0", drop_cnt); end
    checks++; if (err_cnt !== 16'd0) begin failures++; $display("FAIL miss_err got=%0d exp=0", err_cnt); end
  endtask

  task automatic test_bad_sync();
    got_q.delete(); exp_q.delete();
    send_group(A_SFP, A_IP, A_PORT, 3, TS_WORDS, 8'h46);
    repeat (250) tick();
    checks++; if (got_q.size() !== 0) begin failures++; $display("FAIL badsync_count got=%0d exp=0", got_q.size()); end
    checks++; if (err_cnt !== 16'd1) begin failures++; $display("FAIL badsync_err got=%0d exp=1", err_cnt); end
    checks++; if (drop_cnt !== 16'd0) begin failures++; $display("FAIL badsync_drop got=%0d exp=0", drop_cnt); end
  endtask

  task automatic test_truncated();
    got_q.delete(); exp_q.delete();
    expect_pkt(3'd2, 5);
    send_group(A_SFP, A_IP, A_PORT, 4, 20, TS_SYNC);
    send_group(A_SFP, A_IP, A_PORT, 5, TS_WORDS, TS_SYNC);
    repeat (250) tick();
    checks++; if (err_cnt !== 16'd2) begin failures++; $display("FAIL trunc_err got=%0d exp=2", err_cnt); end
    checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL trunc_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL trunc_byte[%0d] got=%03h exp=%03h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_overflow();
    int streak;
    got_q.delete(); exp_q.delete();
    expect_pkt(3'd2, 6);
    expect_pkt(3'd2, 7);
    bus.ts_dout_rdy = 1'b0;
    send_group(A_SFP, A_IP, A_PORT, 6, TS_WORDS, TS_SYNC);
    send_group(A_SFP, A_IP, A_PORT, 7, TS_WORDS, TS_SYNC);
    send_group(A_SFP, A_IP, A_PORT, 8, TS_WORDS, TS_SYNC);
    repeat (5) tick();
    @(negedge clk);
    checks++; if (drop_cnt !== 16'd1) begin failures++; $display("FAIL ovf_drop got=%0d exp=1", drop_cnt); end
    checks++; if (got_q.size() !== 0) begin failures++; $display("FAIL ovf_stalled_count got=%0d exp=0", got_q.size()); end
    checks++; if (bus.ts_dout_en !== 1'b1) begin failures++; $display("FAIL ovf_stall_en got=%0b exp=1", bus.ts_dout_en); end
    repeat (20) @(negedge clk);
    checks++; if (bus.ts_dout !== 8'h47) begin failures++; $display("FAIL ovf_hold_dout got=%02h exp=47", bus.ts_dout); end
    checks++; if (bus.ts_dout_sof !== 1'b1) begin failures++; $display("FAIL ovf_hold_sof got=%0b exp=1", bus.ts_dout_sof); end
    checks++; if (bus.ts_dout_chan !== 3'd2) begin failures++; $display("FAIL ovf_hold_chan got=%0d exp=2", bus.ts_dout_chan); end
    tick();
    bus.ts_dout_rdy = 1'b1;
    streak = 0;
    for (int c = 0; c < 2 * TS_BYTES; c++) begin
      @(negedge clk);
      if (bus.ts_dout_en) streak++;
    end
    checks++; if (streak !== 2 * TS_BYTES) begin failures++; $display("FAIL ovf_b2b_cycles got=%0d exp=%0d", streak, 2 * TS_BYTES); end
    @(negedge clk);
    checks++; if (bus.ts_dout_en !== 1'b0) begin failures++; $display("FAIL ovf_tail_en got=%0b exp=0", bus.ts_dout_en); end
    repeat (50) tick();
    checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL ovf_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL ovf_byte[%0d] got=%03h exp=%03h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_lowest_index();
    got_q.delete(); exp_q.delete();
    cfg_write(3'd6, {1'b1, B_SFP, B_IP, B_PORT});
    cfg_write(3'd5, {1'b1, B_SFP, B_IP, B_PORT});
    send_group(B_SFP, B_IP, B_PORT, 9, TS_WORDS, TS_SYNC);
    repeat (250) tick();
    checks++; if (got_q.size() !== TS_BYTES) begin failures++; $display("FAIL lowest_count got=%0d exp=%0d", got_q.size(), TS_BYTES); end
    if (got_q.size() > 0) begin
      checks++; if (got_q[0] !== {1'b1, 3'd5, 8'h47}) begin failures++; $display("FAIL lowest_first got=%03h exp=%03h", got_q[0], {1'b1, 3'd5, 8'h47}); end
    end
  endtask

  task automatic test_random_rdy();
    got_q.delete(); exp_q.delete();
    for (int p = 0; p < 10; p++) expect_pkt((p % 2 == 0) ? 3'd2 : 3'd5, 10 + p);
    rnd_done = 1'b0;
    fork
      begin
        while (!rnd_done) begin
          bus.ts_dout_rdy = ($urandom_range(0, 3) != 0);
          tick();
        end
      end
      begin
        for (int p = 0; p < 10; p++) begin
          if (p % 2 == 0) send_group(A_SFP, A_IP, A_PORT, 10 + p, TS_WORDS, TS_SYNC);
          else            send_group(B_SFP, B_IP, B_PORT, 10 + p, TS_WORDS, TS_SYNC);
          repeat (300) tick();
        end
        rnd_done = 1'b1;
      end
    join
    bus.ts_dout_rdy = 1'b1;
    repeat (300) tick();
    checks++; if (drop_cnt !== 16'd1) begin failures++; $display("FAIL rnd_drop got=%0d exp=1", drop_cnt); end
    checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL rnd_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rnd_byte[%0d] got=%03h exp=%03h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_output();
    got_q.delete(); exp_q.delete();
    bus.ts_dout_rdy = 1'b1;
    send_group(A_SFP, A_IP, A_PORT, 30, TS_WORDS, TS_SYNC);
    repeat (60) tick();
    checks++; if (bus.ts_dout_en !== 1'b1) begin failures++; $display("FAIL rstmid_pre_en got=%0b exp=1", bus.ts_dout_en); end
    rst = 1'b0;
    #1;
    got_q.delete();
    checks++; if (bus.ts_dout_en !== 1'b0) begin failures++; $display("FAIL rstmid_en got=%0b exp=0", bus.ts_dout_en); end
    checks++; if (bus.ts_dout !== 8'h00) begin failures++; $display("FAIL rstmid_dout got=%02h exp=00", bus.ts_dout); end
    checks++; if (bus.ts_dout_sof !== 1'b0) begin failures++; $display("FAIL rstmid_sof got=%0b exp=0", bus.ts_dout_sof); end
    checks++; if (bus.ts_dout_chan !== 3'd0) begin failures++; $display("FAIL rstmid_chan got=%0d exp=0", bus.ts_dout_chan); end
    checks++; if (drop_cnt !== 16'd0) begin failures++; $display("FAIL rstmid_drop got=%0d exp=0", drop_cnt); end
    checks++; if (err_cnt !== 16'd0) begin failures++; $display("FAIL rstmid_err got=%0d exp=0", err_cnt); end
    repeat (3) tick();
    rst = 1'b1;
    repeat (300) tick();
    checks++; if (got_q.size() !== 0) begin failures++; $display("FAIL rstmid_residual got=%0d exp=0", got_q.size()); end
    checks++; if (dbg_state !== P_IDLE) begin failures++; $display("FAIL rstmid_state got=%0d exp=%0d", dbg_state, P_IDLE); end
    send_group(A_SFP, A_IP, A_PORT, 31, TS_WORDS, TS_SYNC);
    repeat (250) tick();
    checks++; if (got_q.size() !== 0) begin failures++; $display("FAIL rstmid_table_cleared got=%0d exp=0", got_q.size()); end
  endtask

  initial begin
    test_reset();
    cfg_write(3'd2, {1'b1, A_SFP, A_IP, A_PORT});
    test_match();
    test_port_miss();
    test_bad_sync();
    test_truncated();
    test_overflow();
    test_lowest_index();
    test_random_rdy();
    test_reset_mid_output();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ts_chan_filter.md
# ts_chan_filter

Consumes the 33-bit word stream produced by the UDP-to-TS splitter and matches each packet's {sfp, ip, port} tag against a programmable channel table. Matched 188-byte TS packets are stored in a two-bank packet buffer, then replayed as a byte stream tagged with a channel index. Unmatched, malformed or overflowing packets are discarded. The block sits between the splitter and the per-channel TS merge logic.

## Interface
- CHAN_NUM, 8: channel table entries.
- CHAN_W, 3: channel index width; CHAN_NUM ≤ 2**CHAN_W.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- ts_din  in  33  splitter word; bit32 = group-start marker.
- ts_din_en  in  1  ts_din valid. No backpressure; every valid word must be accepted.
- cfg_wr  in  1  table write strobe.
- cfg_addr  in  CHAN_W  table entry index.
- cfg_data  in  57  {valid, sfp[7:0], ip[31:0], port[15:0]}.
- ts_dout  out  8  TS byte.
- ts_dout_en  out  1  byte valid.
- ts_dout_sof  out  1  first byte (0x47) of a packet.
- ts_dout_chan  out  CHAN_W  channel index; constant for the whole packet.
- ts_dout_rdy  in  1  downstream ready. A byte transfers when ts_dout_en & ts_dout_rdy.
- drop_cnt  out  16  packets dropped because no bank was free; saturating.
- err_cnt  out  16  bad sync byte or truncated packets; saturating.

## Operation
- Input group format:
  - H: bit32=1, [7:0]=sfp.
  - IP word: [31:0].
  - PORT word: [15:0].
  - 1..47 TS words: bit32=0, big-endian, first byte in [31:24].
  - Gaps with ts_din_en=0 are allowed anywhere.
- Parser FSM states: P_IDLE, P_IP, P_PORT, P_TS.
  - P_IDLE: a word with bit32=1 latches sfp and moves to P_IP; other words are ignored.
  - P_IP: latches ip and moves to P_PORT.
  - P_PORT: compares {sfp, ip, ts_din[15:0]} in parallel against all valid entries. The lowest matching index wins. Registers hit, chan and bank_ok (the write bank is empty). Moves to P_TS with word count 0.
  - P_TS:
    - Each word increments the word count.
    - Words are written to the write bank only when hit & bank_ok.
    - At word 0, [31:24]≠0x47 marks the packet bad.
    - At word 46: if hit & bank_ok & !bad, commit the bank (full flag set, chan stored) and toggle the write bank. Return to P_IDLE.
- A bit32=1 word in P_IP, P_PORT or P_TS truncates the current group:
  - err_cnt increments if the group had hit.
  - No commit occurs.
  - The word is then processed as a new H, moving to P_IP.
- Counter updates:
  - hit & !bank_ok increments drop_cnt at P_PORT.
  - A bad sync byte with hit increments err_cnt at word 46.
  - A miss is silent.
- Reader:
  - Services banks in commit order.
  - Reads 47 words with a 1-cycle RAM latency.
  - Emits 4 bytes per word, MSB first, for 188 bytes.
  - The bank's full flag clears in the cycle after the 188th byte transfers.
- A table write takes effect for lookups in the next cycle. An in-flight packet keeps its registered chan.

## Timing
- Reset values:
  - All outputs 0.
  - Both banks empty; write and read bank pointers 0.
  - Parser in P_IDLE.
  - Table entries invalid.
- First byte with ts_dout_en=1 appears 2 cycles after the commit cycle, when the reader is idle. ts_dout_sof=1 on that byte only.
- While ts_dout_rdy=0, ts_dout, ts_dout_sof and ts_dout_chan hold stable.
- Back-to-back packets have no idle cycle if the next bank is committed by the last byte of the current one.
- A bank freed in cycle N is visible to the P_PORT check from cycle N+1. A check in the same cycle sees the bank as full.
- Throughput: 1 input word per cycle and 1 output byte per cycle. Sustained input faster than 188 cycles/packet produces drops, counted by drop_cnt.
- Reset asserted mid-packet aborts the packet. No partial output follows deassertion.

## Structure
- Package ts_chan_pkg: TS_WORDS=47, TS_BYTES=188, TS_SYNC=8'h47, parser state encoding, table entry typedef {valid, sfp, ip, port}.
- Sub-module ts_pkt_buf: 2×47×32 simple dual-port RAM, registered read, address {bank, word[5:0]}.
- The table is flops, written through the cfg port.

## Test plan
- Entry 2={1,8'h01,C0A80001,1234}; one matching 188-byte packet, sync 0x47 → 188 bytes out, sof on byte 0 (0x47), chan=2, bytes identical to input.
- Same packet with port 1235 → no output, drop_cnt=0, err_cnt=0.
- Matching packet whose first TS word is 0x46xxxxxx → no output, err_cnt=1.
- Matching group of H, IP, PORT and 20 TS words followed by a new H and a full packet → only the second packet is output, err_cnt=1.
- ts_dout_rdy=0 held; send 3 matching packets → first two buffered, third dropped with drop_cnt=1; release rdy → exactly 376 bytes out, in order.
- Toggle ts_dout_rdy randomly across 10 matching packets → byte order and sof preserved; rst low mid-output → all outputs 0 immediately, no residual bytes afterwards.
